// File: rtl/lockin_tone_detector.sv
// Lock-in tone detector.
// Each accepted phase sample is multiplied by an NCO cos/sin pair. The products
// are integrated over 2^LOG2_N samples, and the I/Q sums are returned through a
// valid/ready handshake.
// ACC_W must be at least PHASE_W+COS_W+LOG2_N so that a full run cannot wrap.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start
// S_ACCUM | accepting samples until 2^LOG2_N have been taken
// S_FLUSH | 3 cycles draining the multiply/accumulate pipeline
// S_DONE  | result presented on i_out_o/q_out_o, waiting for out_ready_i
module lockin_tone_detector #(
    parameter int PHASE_W = 32,
    parameter int FTW_W   = 32,
    parameter int LUT_AW  = 10,
    parameter int COS_W   = 16,
    parameter int LOG2_N  = 4,
    parameter int ACC_W   = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [FTW_W-1:0]          ftw_i,
    input  logic                      in_valid_i,
    input  logic signed [PHASE_W-1:0] phase_in_i,
    output logic                      busy_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic signed [ACC_W-1:0]   i_out_o,
    output logic signed [ACC_W-1:0]   q_out_o
);

    localparam int LUT_DEPTH = 2 ** LUT_AW;
    localparam int PROD_W    = PHASE_W + COS_W;
    localparam logic [LUT_AW-1:0] QUARTER = LUT_AW'(LUT_DEPTH / 4);
    localparam logic [LOG2_N:0]   CNT_ONE = (LOG2_N + 1)'(1);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

    // Full-wave sine table entry. The value is rounded half away from zero.
    function automatic logic signed [COS_W-1:0] lut_entry(input int k);
        real amp;
        real v;
        amp = real'((2 ** (COS_W - 1)) - 1);
        v   = amp * $sin(2.0 * PI * real'(k) / real'(LUT_DEPTH));
        if (v >= 0.0) lut_entry = COS_W'($rtoi(v + 0.5));
        else          lut_entry = COS_W'(-$rtoi(0.5 - v));
    endfunction

    logic signed [COS_W-1:0] sin_tab [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        localparam logic signed [COS_W-1:0] ENTRY = lut_entry(g);
        assign sin_tab[g] = ENTRY;
    end

    state_t                     state_q;
    logic [1:0]                 flush_q;
    logic [FTW_W-1:0]           ftw_q, nco_q, nco_d;
    logic [LOG2_N:0]            cnt_q, cnt_d;
    logic                       start_ok, accept;

    logic                       v0_q, v1_q, v2_q;
    logic signed [PHASE_W-1:0]  ph0_q, ph1_q;
    logic [LUT_AW-1:0]          addr0_q, cos_addr;
    logic signed [COS_W-1:0]    sin1_q, cos1_q;
    logic signed [PROD_W-1:0]   prod_i_q, prod_q_q;
    logic signed [ACC_W-1:0]    acc_i_q, acc_q_q;

    // Start qualification, sample acceptance and next NCO/count values.
    // cnt_q's top bit marks N samples taken and blocks further acceptance.
    always_comb begin
        start_ok = start_i && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i));
        accept   = (state_q == S_ACCUM) && in_valid_i && !cnt_q[LOG2_N];
        nco_d    = nco_q + ftw_q;
        cnt_d    = cnt_q + CNT_ONE;
        cos_addr = addr0_q + QUARTER;
    end

    // Run control: latch the tuning word on start, and advance the NCO only on accepted samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ftw_q <= '0;
            nco_q <= '0;
            cnt_q <= '0;
        end else if (start_ok) begin
            ftw_q <= ftw_i;
            nco_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            nco_q <= nco_d;
            cnt_q <= cnt_d;
        end
    end

    // E0 register sample/address, E1 table read, E2 signed multiply.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            ph0_q    <= '0;
            addr0_q  <= '0;
            ph1_q    <= '0;
            sin1_q   <= '0;
            cos1_q   <= '0;
            prod_i_q <= '0;
            prod_q_q <= '0;
        end else begin
            v0_q <= accept;
            v1_q <= v0_q;
            v2_q <= v1_q;
            if (accept) begin
                ph0_q   <= phase_in_i;
                addr0_q <= nco_q[FTW_W-1 -: LUT_AW];
            end
            if (v0_q) begin
                ph1_q  <= ph0_q;
                sin1_q <= sin_tab[addr0_q];
                cos1_q <= sin_tab[cos_addr];
            end
            if (v1_q) begin
                prod_i_q <= PROD_W'(ph1_q) * PROD_W'(cos1_q);
                prod_q_q <= PROD_W'(ph1_q) * PROD_W'(sin1_q);
            end
        end
    end

    // E3 wrapping accumulation. The pipeline is always empty when a start is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (start_ok) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (v2_q) begin
            acc_i_q <= acc_i_q + ACC_W'(prod_i_q);
            acc_q_q <= acc_q_q + ACC_W'(prod_q_q);
        end
    end

    // Sequencing FSM with registered busy/valid/result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            flush_q     <= '0;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b0;
            i_out_o     <= '0;
            q_out_o     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q <= S_ACCUM;
                        busy_o  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (cnt_q[LOG2_N]) begin
                        state_q <= S_FLUSH;
                        flush_q <= '0;
                    end
                end
                S_FLUSH: begin
                    if (flush_q == 2'd2) begin
                        state_q     <= S_DONE;
                        out_valid_o <= 1'b1;
                        i_out_o     <= acc_i_q;
                        q_out_o     <= acc_q_q;
                    end else begin
                        flush_q <= flush_q + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (start_ok) begin
                            state_q <= S_ACCUM;
                        end else begin
                            state_q <= S_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_o      <= 1'b0;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockin_tone_detector.sv
module tb_lockin_tone_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start = 0, in_valid = 0, ready = 0;
    logic [31:0]        ftw = 0;
    logic signed [31:0] phase = 0;
    logic               busy, ov;
    logic signed [63:0] iout, qout;

    logic               b_start = 0, b_iv = 0, b_ready = 0;
    logic [31:0]        b_ftw = 0;
    logic signed [31:0] b_phase = 0;
    logic               b_busy, b_ov;
    logic signed [63:0] b_i, b_q;

    lockin_tone_detector #(.LOG2_N(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ftw_i(ftw),
        .in_valid_i(in_valid), .phase_in_i(phase), .busy_o(busy),
        .out_valid_o(ov), .out_ready_i(ready), .i_out_o(iout), .q_out_o(qout)
    );

    lockin_tone_detector #(.LOG2_N(10)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .ftw_i(b_ftw),
        .in_valid_i(b_iv), .phase_in_i(b_phase), .busy_o(b_busy),
        .out_valid_o(b_ov), .out_ready_i(b_ready), .i_out_o(b_i), .q_out_o(b_q)
    );

    int     vecs = 0;
    int     errs = 0;
    int     lut_ref [1024];
    int     samp [1024];
    longint DC_I = 64'd524272000;

    // Lock-in sum from the definition: sample k multiplies cos/sin of phase k*ftw.
    function automatic void model(input logic [31:0] f, input int n,
                                  output longint ei, output longint eq);
        logic [31:0] ph;
        int a, c;
        ei = 0; eq = 0; ph = 0;
        for (int k = 0; k < n; k++) begin
            a  = int'(ph >> 22);
            c  = (a + 256) % 1024;
            ei += longint'(samp[k]) * longint'(lut_ref[c]);
            eq += longint'(samp[k]) * longint'(lut_ref[a]);
            ph += f;
        end
    endfunction

    task automatic start_run(input logic [31:0] f);
        start = 1; ftw = f;
        @(negedge clk);
        start = 0; ftw = $urandom;
    endtask

    // Feed 16 samples at the given duty, then count edges until out_valid rises.
    task automatic feed(input int duty, input bit poke_start, output int lat);
        int k = 0;
        int guard = 0;
        while (k < 16 && guard < 2000) begin
            in_valid = ($urandom_range(99) < duty);
            phase    = in_valid ? samp[k] : int'($urandom);
            if (poke_start) begin
                start = 1'($urandom_range(1));
                ftw   = $urandom;
            end
            @(negedge clk);
            if (in_valid) k++;
            guard++;
        end
        start = 0;
        in_valid = 1;
        phase = int'($urandom);
        if (k < 16) begin
            errs++;
            $display("FAIL feed_timeout: accepted %0d samples, required 16", k);
        end
        lat = 0;
        while (!ov && lat < 40) begin
            @(negedge clk);
            lat++;
            phase = int'($urandom);
        end
        in_valid = 0;
    endtask

    task automatic handshake();
        ready = 1;
        @(negedge clk);
        ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        vecs += 4;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (ov !== 1'b0)   begin errs++; $display("FAIL reset_valid: got %b expected 0", ov); end
        if (iout !== 64'sd0) begin errs++; $display("FAIL reset_i: got %0d expected 0", iout); end
        if (qout !== 64'sd0) begin errs++; $display("FAIL reset_q: got %0d expected 0", qout); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_dc(input int duty, input string tag);
        int lat;
        for (int k = 0; k < 16; k++) samp[k] = 1000;
        start_run(32'd0);
        feed(duty, 1'b0, lat);
        vecs += 3;
        if (lat !== 4) begin errs++; $display("FAIL %s_latency: got %0d expected 4", tag, lat); end
        if (iout !== DC_I) begin errs++; $display("FAIL %s_i: got %0d expected %0d", tag, iout, DC_I); end
        if (qout !== 64'sd0) begin errs++; $display("FAIL %s_q: got %0d expected 0", tag, qout); end
        handshake();
        vecs += 3;
        if (ov !== 1'b0) begin errs++; $display("FAIL %s_valid_drop: got %b expected 0", tag, ov); end
        if (busy !== 1'b0) begin errs++; $display("FAIL %s_busy_drop: got %b expected 0", tag, busy); end
        if (iout !== DC_I) begin errs++; $display("FAIL %s_i_hold: got %0d expected %0d", tag, iout, DC_I); end
    endtask

    task automatic test_random_runs();
        int lat;
        logic [31:0] f;
        longint ei, eq;
        for (int r = 0; r < 5; r++) begin
            f = $urandom;
            for (int k = 0; k < 16; k++) samp[k] = int'($urandom);
            model(f, 16, ei, eq);
            start_run(f);
            feed($urandom_range(100, 30), 1'b0, lat);
            vecs += 3;
            if (lat !== 4) begin errs++; $display("FAIL rand%0d_latency: got %0d expected 4", r, lat); end
            if (iout !== ei) begin errs++; $display("FAIL rand%0d_i: got %0d expected %0d", r, iout, ei); end
            if (qout !== eq) begin errs++; $display("FAIL rand%0d_q: got %0d expected %0d", r, qout, eq); end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] f1, f2;
        longint e1i, e1q, e2i, e2q;
        f1 = $urandom;
        for (int k = 0; k < 16; k++) samp[k] = int'($urandom);
        model(f1, 16, e1i, e1q);
        start_run(f1);
        feed(100, 1'b0, lat);
        vecs += 2;
        if (iout !== e1i) begin errs++; $display("FAIL b2b_first_i: got %0d expected %0d", iout, e1i); end
        if (qout !== e1q) begin errs++; $display("FAIL b2b_first_q: got %0d expected %0d", qout, e1q); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(1));
            phase    = int'($urandom);
            start    = 1'($urandom_range(1));
            ftw      = $urandom;
            @(negedge clk);
            vecs += 3;
            if (ov !== 1'b1 || busy !== 1'b1) begin
                errs++; $display("FAIL hold%0d_flags: got valid=%b busy=%b expected 1 1", c, ov, busy);
            end
            if (iout !== e1i) begin errs++; $display("FAIL hold%0d_i: got %0d expected %0d", c, iout, e1i); end
            if (qout !== e1q) begin errs++; $display("FAIL hold%0d_q: got %0d expected %0d", c, qout, e1q); end
        end
        in_valid = 0;
        f2 = $urandom;
        for (int k = 0; k < 16; k++) samp[k] = int'($urandom);
        model(f2, 16, e2i, e2q);
        ready = 1; start = 1; ftw = f2;
        @(negedge clk);
        ready = 0; start = 0; ftw = $urandom;
        vecs += 3;
        if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        if (ov !== 1'b0) begin errs++; $display("FAIL b2b_valid: got %b expected 0", ov); end
        if (iout !== e1i) begin errs++; $display("FAIL b2b_i_keep: got %0d expected %0d", iout, e1i); end
        feed(100, 1'b0, lat);
        vecs += 3;
        if (lat !== 4) begin errs++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        if (iout !== e2i) begin errs++; $display("FAIL b2b_second_i: got %0d expected %0d", iout, e2i); end
        if (qout !== e2q) begin errs++; $display("FAIL b2b_second_q: got %0d expected %0d", qout, e2q); end
        handshake();
    endtask

    task automatic test_reset_mid();
        start_run(32'd0);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1; phase = 1000;
            @(negedge clk);
        end
        in_valid = 0;
        rst_n = 0;
        #1;
        vecs += 4;
        if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (ov !== 1'b0)   begin errs++; $display("FAIL midrst_valid: got %b expected 0", ov); end
        if (iout !== 64'sd0) begin errs++; $display("FAIL midrst_i: got %0d expected 0", iout); end
        if (qout !== 64'sd0) begin errs++; $display("FAIL midrst_q: got %0d expected 0", qout); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_dc(100, "after_rst");
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [31:0] f;
        longint ei, eq;
        f = $urandom;
        for (int k = 0; k < 16; k++) samp[k] = int'($urandom);
        model(f, 16, ei, eq);
        start_run(f);
        feed(70, 1'b1, lat);
        vecs += 3;
        if (lat !== 4) begin errs++; $display("FAIL ignstart_latency: got %0d expected 4", lat); end
        if (iout !== ei) begin errs++; $display("FAIL ignstart_i: got %0d expected %0d", iout, ei); end
        if (qout !== eq) begin errs++; $display("FAIL ignstart_q: got %0d expected %0d", qout, eq); end
        handshake();
    endtask

    task automatic test_tone();
        int lat;
        longint ei, eq, ideal, diff;
        real v;
        for (int k = 0; k < 1024; k++) begin
            v = 1048576.0 * $cos(2.0 * 3.14159265358979323846 * real'(k % 16) / 16.0);
            samp[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        end
        model(32'h1000_0000, 1024, ei, eq);
        b_start = 1; b_ftw = 32'h1000_0000;
        @(negedge clk);
        b_start = 0; b_ftw = 0;
        for (int k = 0; k < 1024; k++) begin
            b_iv = 1; b_phase = samp[k];
            @(negedge clk);
        end
        b_iv = 0;
        lat = 0;
        while (!b_ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ideal = 64'd17591649173504;
        diff  = (b_i > ideal) ? b_i - ideal : ideal - b_i;
        vecs += 5;
        if (lat !== 4) begin errs++; $display("FAIL tone_latency: got %0d expected 4", lat); end
        if (b_i !== ei) begin errs++; $display("FAIL tone_i: got %0d expected %0d", b_i, ei); end
        if (b_q !== eq) begin errs++; $display("FAIL tone_q: got %0d expected %0d", b_q, eq); end
        if (diff > ideal / 100) begin errs++; $display("FAIL tone_i_mag: got %0d expected near %0d", b_i, ideal); end
        if (b_q > ideal / 1000 || b_q < -(ideal / 1000)) begin
            errs++; $display("FAIL tone_q_mag: got %0d expected near 0", b_q);
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
    endtask

    initial begin
        real v;
        for (int k = 0; k < 1024; k++) begin
            v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
            lut_ref[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        end
        test_reset();
        test_dc(100, "dc");
        test_random_runs();
        test_dc(50, "gaps");
        test_back_to_back();
        test_reset_mid();
        test_ignore_start();
        test_tone();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
